// File: rtl/jstk_pkg.sv
// ============================================================================
// Module      : jstk_pkg
// Description : Shared types and constants for the PmodJSTK poll scheduler:
//               FSM state encoding, paddle centre value and the bit positions
//               of the X/Y/button fields inside the 5-byte SPI response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jstk_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // Joystick centre position reported before any poll completes
  localparam logic [9:0] CENTER = 10'd512;

  // Response layout: byte0 in [39:32] ... byte4 in [7:0].
  // X low byte is byte0, X high bits sit in the bottom of byte1.
  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;
  // Y low byte is byte2, Y high bits sit in the bottom of byte3.
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  // Buttons live in the bottom three bits of byte4.
  localparam int BTN_MSB  = 2;
  localparam int BTN_LSB  = 0;

  function automatic logic [9:0] decode_x(input logic [39:0] rx);
    return {rx[X_HI_MSB:X_HI_LSB], rx[X_LO_MSB:X_LO_LSB]};
  endfunction

  function automatic logic [9:0] decode_y(input logic [39:0] rx);
    return {rx[Y_HI_MSB:Y_HI_LSB], rx[Y_LO_MSB:Y_LO_LSB]};
  endfunction

  function automatic logic [2:0] decode_btn(input logic [39:0] rx);
    return rx[BTN_MSB:BTN_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider. Counts 0..DIV-1 and asserts tick for
//               the single cycle in which the count equals DIV-1, then wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] count;

  // Divider counter, wraps after the terminal value
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/jstk_poll_sched.sv
// ============================================================================
// Module      : jstk_poll_sched
// Description : Shares one PmodJSTK SPI master between two joysticks. Each
//               poll tick starts a round: player 0 transaction, a chip-select
//               gap, then player 1. Responses are decoded into registered
//               X/Y/button outputs with a one-cycle valid pulse per player.
//               Optional feature macro: JSTK_TIMEOUT_EN adds a WAIT_DONE
//               watchdog that flags err[player] and moves on.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jstk_poll_sched
  import jstk_pkg::*;
#(
  parameter int POLL_DIV    = 10_000_000,
  parameter int GAP_CYC     = 1500,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  led_cmd0,
  input  logic [7:0]  led_cmd1,
  input  logic        spi_ready,
  input  logic        spi_done,
  input  logic [39:0] spi_rx,
  output logic        spi_start,
  output logic        spi_sel,
  output logic [7:0]  spi_tx,
  output logic [9:0]  x0,
  output logic [9:0]  y0,
  output logic [9:0]  x1,
  output logic [9:0]  y1,
  output logic [2:0]  btn0,
  output logic [2:0]  btn1,
  output logic        valid0,
  output logic        valid1,
  output logic [1:0]  err,
  output logic        ovr
);

  // The gap counter runs 0..GAP_CYC. The first GAP cycle coincides with the
  // player 0 valid pulse, so GAP_CYC idle cycles follow it before player 1
  // is issued.
  localparam int               GAP_W    = $clog2(GAP_CYC + 1) > 0 ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic             tick;
  state_t           state;
  logic             player;
  logic [GAP_W-1:0] gap_cnt;

`ifdef JSTK_TIMEOUT_EN
  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;
`else
  // Without the watchdog a stalled transfer simply holds the FSM.
  assign err = 2'b00;
`endif

  // Poll pacing
  tick_gen #(
    .DIV (POLL_DIV)
  ) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  // Round sequencing FSM with registered SPI request and decoded outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      player    <= 1'b0;
      gap_cnt   <= '0;
      spi_start <= 1'b0;
      spi_sel   <= 1'b0;
      spi_tx    <= 8'd0;
      x0        <= CENTER;
      y0        <= CENTER;
      x1        <= CENTER;
      y1        <= CENTER;
      btn0      <= 3'd0;
      btn1      <= 3'd0;
      valid0    <= 1'b0;
      valid1    <= 1'b0;
      ovr       <= 1'b0;
`ifdef JSTK_TIMEOUT_EN
      wd_cnt    <= '0;
      err       <= 2'b00;
`endif
    end else begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;

      // A tick landing mid-round is discarded but remembered.
      if (tick && (state != ST_IDLE)) begin
        ovr <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (tick && en) begin
            state     <= ST_ISSUE;
            player    <= 1'b0;
            spi_start <= 1'b1;
            spi_sel   <= 1'b0;
            spi_tx    <= led_cmd0;
          end
        end

        ST_ISSUE: begin
          if (spi_start && spi_ready) begin
            state     <= ST_WAIT_DONE;
            spi_start <= 1'b0;
`ifdef JSTK_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end

        ST_WAIT_DONE: begin
          if (spi_done) begin
            if (player == 1'b0) begin
              x0      <= decode_x(spi_rx);
              y0      <= decode_y(spi_rx);
              btn0    <= decode_btn(spi_rx);
              valid0  <= 1'b1;
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              x1      <= decode_x(spi_rx);
              y1      <= decode_y(spi_rx);
              btn1    <= decode_btn(spi_rx);
              valid1  <= 1'b1;
              state   <= ST_IDLE;
            end
          end
`ifdef JSTK_TIMEOUT_EN
          // Done in the same cycle as expiry takes priority above.
          else if (wd_cnt == WD_LAST) begin
            err[player] <= 1'b1;
            if (player == 1'b0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state   <= ST_IDLE;
            end
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
`endif
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state     <= ST_ISSUE;
            player    <= 1'b1;
            spi_start <= 1'b1;
            spi_sel   <= 1'b1;
            spi_tx    <= led_cmd1;
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jstk_poll_sched.sv
// ============================================================================
// Module      : tb_jstk_poll_sched
// Description : Directed bench for jstk_poll_sched with a scoreboard fed at
//               SPI acceptance and drained on each valid pulse. Covers reset,
//               nominal round, backpressure, overrun, enable drop, mid-round
//               reset and (with JSTK_TIMEOUT_EN) the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jstk_poll_sched;

  localparam int         POLL_DIV    = 100;
  localparam int         GAP_CYC     = 4;
  localparam int         TIMEOUT_CYC = 50;
  localparam logic [9:0] CTR         = 10'd512;

  logic        clk = 1'b0;
  logic        clr, en, spi_ready;
  logic        spi_done = 1'b0;
  logic [39:0] spi_rx   = 40'd0;
  logic [7:0]  led_cmd0, led_cmd1;
  logic        spi_start, spi_sel;
  logic [7:0]  spi_tx;
  logic [9:0]  x0, y0, x1, y1;
  logic [2:0]  btn0, btn1;
  logic        valid0, valid1, ovr;
  logic [1:0]  err;

  always #5 clk = ~clk;

  jstk_poll_sched #(
    .POLL_DIV    (POLL_DIV),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .led_cmd0  (led_cmd0),
    .led_cmd1  (led_cmd1),
    .spi_ready (spi_ready),
    .spi_done  (spi_done),
    .spi_rx    (spi_rx),
    .spi_start (spi_start),
    .spi_sel   (spi_sel),
    .spi_tx    (spi_tx),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .btn0      (btn0),
    .btn1      (btn1),
    .valid0    (valid0),
    .valid1    (valid1),
    .err       (err),
    .ovr       (ovr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response data per player and the outputs it must decode to {p,x,y,btn}
  logic [39:0] rx_tab  [2] = '{40'h3A_02_C5_01_05, 40'h7F_03_10_02_06};
  logic [23:0] exp_tab [2] = '{{1'b0, 10'h23A, 10'h1C5, 3'b101},
                               {1'b1, 10'h37F, 10'h210, 3'b110}};
  logic [23:0] sb_q [$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // SPI master model: acceptance seen at the clock edge, done driven mid-cycle
  int   lat_p [2] = '{3, 3};
  bit   skip_p0   = 1'b0;
  int   acc_cnt   = 0;
  int   seen_cnt  = 0;
  logic acc_player = 1'b0;
  bit   pend      = 1'b0;
  int   rem       = 0;

  always @(posedge clk) begin
    if (!clr && spi_start && spi_ready) begin
      acc_cnt++;
      acc_player = spi_sel;
      if (!(skip_p0 && !spi_sel)) sb_q.push_back(exp_tab[spi_sel]);
    end
  end

  always @(negedge clk) begin
    spi_done = 1'b0;
    if (acc_cnt != seen_cnt) begin
      seen_cnt = acc_cnt;
      if (!(skip_p0 && !acc_player)) begin
        pend   = 1'b1;
        rem    = lat_p[acc_player] - 1;
        spi_rx = rx_tab[acc_player];
      end
    end
    if (pend) begin
      if (rem == 0) begin
        spi_done = 1'b1;
        pend     = 1'b0;
      end else begin
        rem--;
      end
    end
  end

  // Output monitor: event counters plus scoreboard drain
  int   rise_cnt = 0, rise_cyc = 0;
  int   v0_cnt = 0, v0_cyc = 0, v1_cnt = 0, v1_cyc = 0;
  logic prev_start = 1'b0, prev_v0 = 1'b0, prev_v1 = 1'b0;

  task automatic sb_pop(input logic p);
    logic [23:0] e;
    logic [23:0] got;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_valid", sb_q.size(), 1);
    end else begin
      e   = sb_q.pop_front();
      got = p ? {1'b1, x1, y1, btn1} : {1'b0, x0, y0, btn0};
      check("sb_player_outputs", got, e);
    end
  endtask

  always @(negedge clk) begin
    if (spi_start === 1'b1 && prev_start === 1'b0) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (prev_v0) check("valid0_width", valid0, 1'b0);
    if (prev_v1) check("valid1_width", valid1, 1'b0);
    if (valid0 === 1'b1) begin v0_cnt++; v0_cyc = cyc; sb_pop(1'b0); end
    if (valid1 === 1'b1) begin v1_cnt++; v1_cyc = cyc; sb_pop(1'b1); end
    prev_start = spi_start;
    prev_v0    = valid0;
    prev_v1    = valid1;
  end

  int rel = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en_after);
    clr = 1'b1;
    en  = 1'b0;
    repeat (60) step();
    sb_q.delete();
    clr = 1'b0;
    en  = en_after;
    rel = cyc;
  endtask

  task automatic wait_rise(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (rise_cnt < target && n < max_cyc) begin step(); n++; end
    check(tag, (rise_cnt >= target), 1'b1);
  endtask

  task automatic wait_valid(input logic p, input int target, input int max_cyc, input string tag);
    int n = 0;
    while ((p ? v1_cnt : v0_cnt) < target && n < max_cyc) begin step(); n++; end
    check(tag, ((p ? v1_cnt : v0_cnt) >= target), 1'b1);
  endtask

  initial begin
    int a0, s1, r, base_acc, vb;
    bit ok;
    clr = 1'b1; en = 1'b0; spi_ready = 1'b1;
    led_cmd0 = 8'hA1; led_cmd1 = 8'hB2;

    // ---------------- reset state ----------------
    do_reset(1'b0);
    check("rst_spi",   {spi_start, spi_sel, spi_tx}, 10'd0);
    check("rst_pos0",  {x0, y0}, {CTR, CTR});
    check("rst_pos1",  {x1, y1}, {CTR, CTR});
    check("rst_btn",   {btn0, btn1}, 6'd0);
    check("rst_flags", {valid0, valid1, err, ovr}, 5'd0);

`ifdef JSTK_TIMEOUT_EN
    // ---------------- watchdog ----------------
    skip_p0 = 1'b1;
    do_reset(1'b1);
    r = rise_cnt; vb = v0_cnt;
    wait_rise(r + 1, 150, "to_rise0");
    a0 = rise_cyc;
    repeat (TIMEOUT_CYC) step();
    check("to_err_before", err, 2'b00);
    step();
    check("to_err_set", err, 2'b01);
    check("to_pos0_kept", {x0, y0}, {CTR, CTR});
    wait_valid(1'b1, v1_cnt + 1, 100, "to_p1_polled");
    check("to_no_valid0", v0_cnt - vb, 0);
    check("to_err_p1_clean", err, 2'b01);
    check("to_elapsed", cyc - a0 < 200, 1'b1);
    skip_p0 = 1'b0;
`endif

    // ---------------- nominal round ----------------
    do_reset(1'b1);
    r = rise_cnt;
    wait_rise(r + 1, 150, "nom_rise0");
    check("nom_rise_time", rise_cyc - rel, POLL_DIV);
    check("nom_p0_cmd", {spi_sel, spi_tx}, {1'b0, 8'hA1});
    a0 = rise_cyc;
    step();
    check("nom_start_drop", spi_start, 1'b0);
    wait_valid(1'b0, v0_cnt + 1, 20, "nom_valid0");
    check("nom_valid0_time", v0_cyc - a0, 4);
    check("nom_x0", x0, 10'h23A);
    check("nom_y0", y0, 10'h1C5);
    check("nom_btn0", btn0, 3'b101);
    check("nom_ovr_clear", ovr, 1'b0);
    wait_rise(r + 2, 20, "nom_rise1");
    check("nom_p1_start_gap", rise_cyc - v0_cyc, GAP_CYC + 1);
    check("nom_p1_cmd", {spi_sel, spi_tx}, {1'b1, 8'hB2});
    ok = 1'b1; vb = v1_cnt;
    for (int i = 0; i < 20 && v1_cnt == vb; i++) begin
      if (spi_sel !== 1'b1) ok = 1'b0;
      step();
    end
    check("nom_p1_sel_held", ok, 1'b1);
    check("nom_valid1", v1_cnt - vb, 1);

    // ---------------- backpressure ----------------
    spi_ready = 1'b0;
    r = rise_cnt;
    wait_rise(r + 1, 150, "bp_rise");
    base_acc = acc_cnt;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (!(spi_start === 1'b1 && spi_tx === 8'hA1 && spi_sel === 1'b0)) ok = 1'b0;
      step();
    end
    check("bp_hold", ok, 1'b1);
    check("bp_no_accept_low", acc_cnt - base_acc, 0);
    spi_ready = 1'b1;
    step();
    check("bp_start_drop", spi_start, 1'b0);
    check("bp_single_accept", acc_cnt - base_acc, 1);
    wait_valid(1'b1, v1_cnt + 1, 40, "bp_round_done");

    // ---------------- overrun ----------------
    // 48-cycle latency stays under the watchdog limit yet makes the round
    // longer than the poll period in either build.
    lat_p[0] = 48; lat_p[1] = 48;
    do_reset(1'b1);
    r = rise_cnt;
    wait_rise(r + 1, 150, "ovr_rise0");
    s1 = rise_cyc;
    wait_valid(1'b0, v0_cnt + 1, 80, "ovr_valid0");
    check("ovr_clear_early", ovr, 1'b0);
    wait_valid(1'b1, v1_cnt + 1, 80, "ovr_valid1");
    check("ovr_set", ovr, 1'b1);
    wait_rise(r + 3, 150, "ovr_next_rise");
    check("ovr_next_round", rise_cyc - s1, 2 * POLL_DIV);
    wait_valid(1'b1, v1_cnt + 1, 150, "ovr_round2_done");
    lat_p[0] = 3; lat_p[1] = 3;

    // ---------------- enable drop ----------------
    do_reset(1'b1);
    r = rise_cnt;
    wait_rise(r + 1, 150, "en_rise0");
    wait_valid(1'b0, v0_cnt + 1, 20, "en_valid0");
    en = 1'b0;
    wait_valid(1'b1, v1_cnt + 1, 30, "en_p1_completes");
    r = rise_cnt;
    repeat (250) step();
    check("en_no_new_round", rise_cnt - r, 0);

    // ---------------- mid-round reset ----------------
    lat_p[1] = 20;
    do_reset(1'b1);
    r = rise_cnt;
    wait_rise(r + 2, 200, "mr_rise1");
    repeat (5) step();
    clr = 1'b1;
    step();
    check("mr_spi",   {spi_start, spi_sel, spi_tx}, 10'd0);
    check("mr_pos",   {x0, y0, x1, y1}, {CTR, CTR, CTR, CTR});
    check("mr_flags", {btn0, btn1, valid0, valid1, err, ovr}, 11'd0);
    clr = 1'b0;
    rel = cyc;
    sb_q.delete();
    vb = v1_cnt;
    repeat (30) step();
    check("mr_late_done_ignored", v1_cnt - vb, 0);
    check("mr_pos1_kept", {x1, y1, btn1}, {CTR, CTR, 3'd0});
    r = rise_cnt;
    wait_rise(r + 1, 150, "mr_restart");
    check("mr_counter_restart", rise_cyc - rel, POLL_DIV);
    wait_valid(1'b1, v1_cnt + 1, 60, "mr_round_done");
    lat_p[1] = 3;

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
